// File: rtl/spi_cmd_parser.sv
// -----------------------------------------------------------------------------
// spi_cmd_parser
//
// Parses framed SPI command sequences into register-write transactions.
// A frame is one chip-select-low period. The first byte of a frame is an
// opcode. A write opcode is followed by an address byte and then a burst of
// data bytes. Each data byte produces one write, and the address increments
// after each write.
//
// Ports:
//   i_clk          system clock (same domain as the SPI byte receiver)
//   i_reset        synchronous, active-high reset
//   i_ssel         raw chip select from the pin, active low, asynchronous
//   i_cmd          received byte from the byte receiver
//   i_cmd_valid    byte valid; a new byte is signalled by its 0->1 edge
//   o_wr_en        one-cycle register write strobe
//   o_wr_addr      write address; holds its last value when o_wr_en=0
//   o_wr_data      write data; holds its last value when o_wr_en=0
//   o_busy         high while a frame is being parsed (state != IDLE)
//   o_err_count    frames with an unknown opcode, saturating at 8'hFF
//   o_frame_count  completed frames of any opcode, wrapping at 8'hFF
// -----------------------------------------------------------------------------
module spi_cmd_parser #(
    parameter int          ADDR_W   = 8,
    parameter logic [7:0]  OP_WRITE = 8'h02,
    parameter logic [7:0]  OP_NOP   = 8'h00
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_ssel,
    input  logic [7:0]        i_cmd,
    input  logic              i_cmd_valid,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [7:0]        o_wr_data,
    output logic              o_busy,
    output logic [7:0]        o_err_count,
    output logic [7:0]        o_frame_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_SKIP = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic               r_ssel_meta;
    logic               r_ssel_s;
    logic               r_ssel_s_d;
    logic [1:0]         r_sync_live;
    logic               r_armed;
    logic               r_cmd_valid_d;

    logic [ADDR_W-1:0]  r_addr;
    logic [ADDR_W-1:0]  w_addr_next;
    logic               r_wr_en;
    logic               w_wr_en_next;
    logic [ADDR_W-1:0]  r_wr_addr;
    logic [ADDR_W-1:0]  w_wr_addr_next;
    logic [7:0]         r_wr_data;
    logic [7:0]         w_wr_data_next;
    logic [7:0]         r_err_count;
    logic [7:0]         r_frame_count;
    logic               w_err_inc;
    logic               w_frame_inc;

    logic               w_frame_end;
    logic               w_byte_stb;

    // Frame end is the rising edge of the synchronized chip select.
    assign w_frame_end = r_ssel_s & ~r_ssel_s_d;

    // A byte counts only on the 0->1 edge of cmd_valid, only inside a frame,
    // and never in the cycle the frame ends (frame end wins the collision).
    // r_armed blocks parsing after reset until the pin has been seen
    // deselected, so the tail of a frame interrupted by reset is ignored.
    assign w_byte_stb = i_cmd_valid & ~r_cmd_valid_d & ~r_ssel_s
                        & r_armed & ~w_frame_end;

    // -------------------------------------------------------------------------
    // Synchronizer, edge detectors and arming
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ssel_meta   <= 1'b1;
            r_ssel_s      <= 1'b1;
            r_ssel_s_d    <= 1'b1;
            r_sync_live   <= 2'b00;
            r_armed       <= 1'b0;
            r_cmd_valid_d <= 1'b0;
        end else begin
            r_ssel_meta   <= i_ssel;
            r_ssel_s      <= r_ssel_meta;
            r_ssel_s_d    <= r_ssel_s;
            r_cmd_valid_d <= i_cmd_valid;
            // r_sync_live[1] means r_ssel_s now reflects the pin. Before that,
            // it still shows the reset value and cannot be trusted.
            r_sync_live   <= {r_sync_live[0], 1'b1};
            if (r_sync_live[1] && r_ssel_s) begin
                r_armed <= 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // FSM state register and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= ST_IDLE;
            r_addr        <= '0;
            r_wr_en       <= 1'b0;
            r_wr_addr     <= '0;
            r_wr_data     <= 8'h00;
            r_err_count   <= 8'h00;
            r_frame_count <= 8'h00;
        end else begin
            r_state   <= w_state_next;
            r_addr    <= w_addr_next;
            r_wr_en   <= w_wr_en_next;
            r_wr_addr <= w_wr_addr_next;
            r_wr_data <= w_wr_data_next;
            if (w_err_inc && (r_err_count != 8'hFF)) begin
                r_err_count <= r_err_count + 8'd1;
            end
            if (w_frame_inc) begin
                r_frame_count <= r_frame_count + 8'd1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next   = r_state;
        w_addr_next    = r_addr;
        w_wr_en_next   = 1'b0;
        w_wr_addr_next = r_wr_addr;
        w_wr_data_next = r_wr_data;
        w_err_inc      = 1'b0;
        w_frame_inc    = 1'b0;

        if (w_frame_end) begin
            if (r_state != ST_IDLE) begin
                w_state_next = ST_IDLE;
                w_frame_inc  = 1'b1;
            end
        end else if (w_byte_stb) begin
            case (r_state)
                ST_IDLE: begin
                    if (i_cmd == OP_WRITE) begin
                        w_state_next = ST_ADDR;
                    end else begin
                        // NOP and unknown opcodes both skip the rest of the frame.
                        w_state_next = ST_SKIP;
                        w_err_inc    = (i_cmd != OP_NOP);
                    end
                end
                ST_ADDR: begin
                    w_addr_next  = i_cmd[ADDR_W-1:0];
                    w_state_next = ST_DATA;
                end
                ST_DATA: begin
                    w_wr_en_next   = 1'b1;
                    w_wr_addr_next = r_addr;
                    w_wr_data_next = i_cmd;
                    w_addr_next    = r_addr + ADDR_W'(1);
                end
                default: begin
                    // ST_SKIP: bytes are ignored until frame end.
                end
            endcase
        end
    end

    assign o_wr_en       = r_wr_en;
    assign o_wr_addr     = r_wr_addr;
    assign o_wr_data     = r_wr_data;
    assign o_busy        = (r_state != ST_IDLE);
    assign o_err_count   = r_err_count;
    assign o_frame_count = r_frame_count;

endmodule
